// File: rtl/crc32_sched_pkg.sv
// crc32_sched_pkg: shared types and constants for the CRC-32 frame scheduler
package crc32_sched_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, RESULT} state_t;
  localparam logic [32:0] CRC32_POLY = 33'h1_04C11DB7;
  localparam logic [31:0] CRC_INIT_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] XOR_OUT_DEF = 32'hFFFF_FFFF;
endpackage

// File: rtl/crc32_rr_arb.sv
// crc32_rr_arb: combinational round-robin pick of the first request after ptr
module crc32_rr_arb
  import crc32_sched_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CHW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CHW-1:0]  ptr,
  output logic [N_CH-1:0] gnt,
  output logic [CHW-1:0]  idx
);
  int c;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    found = 1'b0;
    c = 0;
    for (int i = 1; i <= N_CH; i++) begin
      c = (int'(ptr) + i) % N_CH;
      if (!found && req[c]) begin
        found = 1'b1;
        gnt[c] = 1'b1;
        idx = CHW'(c);
      end
    end
  end
endmodule

// File: rtl/crc32_frame_sched.sv
// crc32_frame_sched: shares one word-serial CRC-32 engine among N_CH frame requesters
module crc32_frame_sched
  import crc32_sched_pkg::*;
#(
  parameter int          N_CH     = 4,
  parameter logic [31:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [31:0] XOR_OUT  = XOR_OUT_DEF,
  parameter int          TIMEOUT  = 63,
  localparam int         CHW      = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]    req_valid,
  input  logic [N_CH*32-1:0] req_data,
  input  logic [N_CH-1:0]    req_last,
  output logic [N_CH-1:0]    req_ready,
  output logic             eng_load,
  output logic [31:0]      eng_data,
  output logic [31:0]      eng_crc_in,
  input  logic             eng_done,
  input  logic [31:0]      eng_crc,
  output logic             res_valid,
  output logic [CHW-1:0]   res_ch,
  output logic [31:0]      res_crc,
  input  logic             res_ready,
  output logic             err_timeout
);
  state_t state;
  logic [CHW-1:0]  g, ptr, arb_idx;
  logic [N_CH-1:0] gh, arb_gnt;
  logic [31:0]     running;
  logic            last;
  logic [7:0]      cnt;

  crc32_rr_arb #(.N_CH(N_CH)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  assign req_ready = (state == FETCH) ? gh : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      g           <= '0;
      gh          <= '0;
      ptr         <= CHW'(N_CH - 1);
      running     <= CRC_INIT;
      last        <= 1'b0;
      cnt         <= '0;
      eng_load    <= 1'b0;
      eng_data    <= '0;
      eng_crc_in  <= '0;
      res_valid   <= 1'b0;
      res_ch      <= '0;
      res_crc     <= '0;
      err_timeout <= 1'b0;
    end else begin
      eng_load    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: if (|req_valid) begin
          g       <= arb_idx;
          gh      <= arb_gnt;
          running <= CRC_INIT;
          state   <= FETCH;
        end
        FETCH: if (req_valid[g]) begin
          eng_data   <= req_data[32*g +: 32];
          eng_crc_in <= running;
          last       <= req_last[g];
          eng_load   <= 1'b1;
          state      <= LOAD;
        end
        LOAD: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: if (eng_done) begin
          running <= eng_crc;
          if (last) begin
            res_valid <= 1'b1;
            res_ch    <= g;
            res_crc   <= eng_crc ^ XOR_OUT;
            state     <= RESULT;
          end else begin
            state <= FETCH;
          end
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          // abort lands exactly TIMEOUT+1 cycles after the load strobe
          err_timeout <= 1'b1;
          ptr         <= g;
          state       <= IDLE;
        end else begin
          cnt <= cnt + 8'd1;
        end
        RESULT: if (res_ready) begin
          res_valid <= 1'b0;
          ptr       <= g;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
